// File: rtl/flow_ctrl_pkg.sv
// Shared definitions for the multi-channel flow controller.
// Holds the one-hot channel state encoding, the fill-level class encoding
// and the watermark classification helper used by every channel.
package flow_ctrl_pkg;

  // One-hot channel states, exported on the debug state port
  typedef enum logic [3:0] {
    INIT        = 4'b0001,
    SPACE       = 4'b0010,
    ALMOST_FULL = 4'b0100,
    FULL        = 4'b1000
  } state_t;

  // Fill classes: MIDC is the hysteresis band between the two watermarks
  typedef enum logic [1:0] {
    LOWC  = 2'd0,
    MIDC  = 2'd1,
    HIGHC = 2'd2,
    FULLC = 2'd3
  } fill_cls_t;

  // Anything at or above depth counts as full, so an out-of-range fill
  // never wraps into a lower class.
  function automatic fill_cls_t classify(input int fill, input int depth,
                                         input int high_mark, input int low_mark);
    if (fill >= depth)          return FULLC;
    else if (fill >= high_mark) return HIGHC;
    else if (fill <= low_mark)  return LOWC;
    else                        return MIDC;
  endfunction

endpackage

// File: rtl/flow_ctrl_ch.sv
// One flow-control channel: watermark FSM with registered producer enable,
// sticky overflow flag and saturating stall counter.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   fill        : FIFO fill level for this channel
//   wr          : FIFO write strobe (used for overflow detection)
//   clr         : clears ovf and stall_cnt
//   enable      : registered producer enable
//   state       : one-hot FSM state for debug
//   ovf         : sticky overflow flag
//   stall_cnt   : saturating count of cycles with enable low
module flow_ctrl_ch
  import flow_ctrl_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int HIGH_MARK = 12,
  parameter int LOW_MARK  = 4,
  parameter int STALL_W   = 16,
  parameter int CNT_W     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   fill,
  input  logic               wr,
  input  logic               clr,
  output logic               enable,
  output logic [3:0]         state,
  output logic               ovf,
  output logic [STALL_W-1:0] stall_cnt
);

  fill_cls_t          cls;
  logic [3:0]         state_q;
  logic               enable_q;
  logic               ovf_q;
  logic [STALL_W-1:0] stall_q;

  assign cls       = classify(int'(fill), DEPTH, HIGH_MARK, LOW_MARK);
  assign enable    = enable_q;
  assign state     = state_q;
  assign ovf       = ovf_q;
  assign stall_cnt = stall_q;

  // Watermark FSM. Enable is registered next to the state so it always
  // matches it; any corrupted (non-one-hot) state recovers through INIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= INIT;
      enable_q <= 1'b1;
    end else begin
      case (state_q)
        INIT, SPACE, ALMOST_FULL, FULL: begin
          case (cls)
            FULLC: begin
              state_q  <= FULL;
              enable_q <= 1'b0;
            end
            HIGHC: begin
              state_q  <= ALMOST_FULL;
              enable_q <= 1'b0;
            end
            LOWC: begin
              state_q  <= SPACE;
              enable_q <= 1'b1;
            end
            default: begin
              // Inside the hysteresis band: keep the current enable polarity
              if (state_q == INIT || state_q == SPACE) begin
                state_q  <= SPACE;
                enable_q <= 1'b1;
              end else begin
                state_q  <= ALMOST_FULL;
                enable_q <= 1'b0;
              end
            end
          endcase
        end
        default: begin
          state_q  <= INIT;
          enable_q <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overflow: a write into a full FIFO beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset)                   ovf_q <= 1'b0;
    else if (wr && cls == FULLC) ovf_q <= 1'b1;
    else if (clr)                ovf_q <= 1'b0;
  end

  // Stall counter follows the channel's own enable register, not the ganged one
  always_ff @(posedge clk) begin
    if (reset)                                          stall_q <= '0;
    else if (clr)                                       stall_q <= '0;
    else if (!enable_q && stall_q != {STALL_W{1'b1}})  stall_q <= stall_q + STALL_W'(1);
  end

endmodule

// File: rtl/flow_ctrl_mc.sv
// Multi-channel producer flow controller. Instantiates one flow_ctrl_ch per
// channel, slices the packed buses and optionally gangs all enables together.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   fill        : packed fill levels, channel i at [i*CNT_W +: CNT_W]
//   wr, clr     : per-channel write strobe and ovf/stall clear
//   enable      : per-channel producer enable (AND of all channels when GANG=1)
//   state       : packed one-hot states, 4 bits per channel
//   ovf         : per-channel sticky overflow
//   stall_cnt   : packed stall counters, STALL_W bits per channel
module flow_ctrl_mc
  import flow_ctrl_pkg::*;
#(
  parameter  int NUM_CH    = 2,
  parameter  int DEPTH     = 16,
  parameter  int HIGH_MARK = 12,
  parameter  int LOW_MARK  = 4,
  parameter  int STALL_W   = 16,
  parameter  int GANG      = 0,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH*CNT_W-1:0]   fill,
  input  logic [NUM_CH-1:0]         wr,
  input  logic [NUM_CH-1:0]         clr,
  output logic [NUM_CH-1:0]         enable,
  output logic [NUM_CH*4-1:0]       state,
  output logic [NUM_CH-1:0]         ovf,
  output logic [NUM_CH*STALL_W-1:0] stall_cnt
);

  logic [NUM_CH-1:0] ch_en;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    flow_ctrl_ch #(
      .DEPTH     (DEPTH),
      .HIGH_MARK (HIGH_MARK),
      .LOW_MARK  (LOW_MARK),
      .STALL_W   (STALL_W),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .fill      (fill[i*CNT_W +: CNT_W]),
      .wr        (wr[i]),
      .clr       (clr[i]),
      .enable    (ch_en[i]),
      .state     (state[i*4 +: 4]),
      .ovf       (ovf[i]),
      .stall_cnt (stall_cnt[i*STALL_W +: STALL_W])
    );
  end

  // Ganging only affects the outputs; each channel keeps its own state
  if (GANG != 0) begin : g_gang
    assign enable = {NUM_CH{&ch_en}};
  end else begin : g_indep
    assign enable = ch_en;
  end

  if (!(LOW_MARK < HIGH_MARK && HIGH_MARK <= DEPTH)) begin : g_bad_marks
    $error("flow_ctrl_mc: watermarks must satisfy LOW_MARK < HIGH_MARK <= DEPTH");
  end

endmodule

// File: tb/tb_flow_ctrl_mc.sv
// Scoreboard bench for flow_ctrl_mc. dut_a: 2 channels, STALL_W=4, GANG=0.
// dut_g: 2 channels, STALL_W=16, GANG=1. Every stimulus cycle pushes one
// expectation entry; the monitor pops one entry after each rising edge.
module tb_flow_ctrl_mc;

  localparam logic [5:0] M_EN  = 6'b100000;
  localparam logic [5:0] M_ST  = 6'b010000;
  localparam logic [5:0] M_OV  = 6'b001000;
  localparam logic [5:0] M_SC  = 6'b000100;
  localparam logic [5:0] M_GEN = 6'b000010;
  localparam logic [5:0] M_GST = 6'b000001;

  typedef struct {
    string      tag;
    logic [5:0] m;
    logic [1:0] en;
    logic [7:0] st;
    logic [1:0] ov;
    logic [7:0] sc;
    logic [1:0] gen;
    logic [7:0] gst;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  fill_a, fill_g;
  logic [1:0]  wr_a, clr_a, wr_g, clr_g;
  logic [1:0]  en_a, ov_a, en_g, ov_g;
  logic [7:0]  st_a, st_g, sc_a;
  logic [31:0] sc_g;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flow_ctrl_mc #(.NUM_CH(2), .DEPTH(16), .HIGH_MARK(12), .LOW_MARK(4),
                 .STALL_W(4), .GANG(0)) dut_a (
    .clk(clk), .reset(reset), .fill(fill_a), .wr(wr_a), .clr(clr_a),
    .enable(en_a), .state(st_a), .ovf(ov_a), .stall_cnt(sc_a));

  flow_ctrl_mc #(.NUM_CH(2), .DEPTH(16), .HIGH_MARK(12), .LOW_MARK(4),
                 .STALL_W(16), .GANG(1)) dut_g (
    .clk(clk), .reset(reset), .fill(fill_g), .wr(wr_g), .clr(clr_g),
    .enable(en_g), .state(st_g), .ovf(ov_g), .stall_cnt(sc_g));

  task automatic checkOutput(input string tag, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s got %h expected %h", tag, field, act, exp);
    end
  endtask

  // Drive is set by the caller at a falling edge; this queues what the DUT
  // must show after the next rising edge and moves on to the next falling edge.
  task automatic applyStimulus(input string tag, input logic [5:0] m,
                               input logic [1:0] en, input logic [7:0] st,
                               input logic [1:0] ov, input logic [7:0] sc,
                               input logic [1:0] gen, input logic [7:0] gst);
    exp_t e;
    e.tag = tag; e.m = m; e.en = en; e.st = st; e.ov = ov; e.sc = sc;
    e.gen = gen; e.gst = gst;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.m[5]) checkOutput(e.tag, "enable",    32'(en_a), 32'(e.en));
        if (e.m[4]) checkOutput(e.tag, "state",     32'(st_a), 32'(e.st));
        if (e.m[3]) checkOutput(e.tag, "ovf",       32'(ov_a), 32'(e.ov));
        if (e.m[2]) checkOutput(e.tag, "stall_cnt", 32'(sc_a), 32'(e.sc));
        if (e.m[1]) checkOutput(e.tag, "g_enable",  32'(en_g), 32'(e.gen));
        if (e.m[0]) checkOutput(e.tag, "g_state",   32'(st_g), 32'(e.gst));
      end
    end
  end

  // Stimulus
  initial begin
    int c;
    reset = 1'b1; fill_a = '0; fill_g = '0;
    wr_a = '0; clr_a = '0; wr_g = '0; clr_g = '0;
    @(negedge clk);
    $display("[TB] reset and idle");
    applyStimulus("reset", 6'h3f, 2'b11, 8'h11, 2'b00, 8'h00, 2'b11, 8'h11);
    reset = 1'b0;
    applyStimulus("post_reset", 6'h3f, 2'b11, 8'h22, 2'b00, 8'h00, 2'b11, 8'h22);

    $display("[TB] ramp channel 0");
    for (int v = 0; v <= 16; v++) begin
      fill_a = {5'd0, 5'(v)};
      applyStimulus($sformatf("ramp_up_%0d", v), M_EN | M_ST,
                    {1'b1, 1'(v < 12)},
                    {4'b0010, (v >= 16) ? 4'b1000 : ((v >= 12) ? 4'b0100 : 4'b0010)},
                    2'b00, 8'h00, 2'b00, 8'h00);
    end
    for (int v = 15; v >= 0; v--) begin
      fill_a = {5'd0, 5'(v)};
      applyStimulus($sformatf("ramp_down_%0d", v), M_EN | M_ST,
                    {1'b1, 1'(v <= 4)},
                    {4'b0010, (v <= 4) ? 4'b0010 : 4'b0100},
                    2'b00, 8'h00, 2'b00, 8'h00);
    end

    $display("[TB] hysteresis");
    for (int i = 0; i < 8; i++) begin
      fill_a = {5'd0, (i % 2 == 1) ? 5'd10 : 5'd6};
      applyStimulus("hyst_space", M_EN | M_ST, 2'b11, 8'h22, 2'b00, 8'h00, 2'b00, 8'h00);
    end
    fill_a = {5'd0, 5'd12};
    applyStimulus("hyst_enter_af", M_EN | M_ST, 2'b10, 8'h24, 2'b00, 8'h00, 2'b00, 8'h00);
    for (int i = 0; i < 8; i++) begin
      fill_a = {5'd0, (i % 2 == 1) ? 5'd10 : 5'd6};
      applyStimulus("hyst_af", M_EN | M_ST, 2'b10, 8'h24, 2'b00, 8'h00, 2'b00, 8'h00);
    end
    fill_a = '0;
    applyStimulus("hyst_exit", M_EN | M_ST, 2'b11, 8'h22, 2'b00, 8'h00, 2'b00, 8'h00);

    $display("[TB] overflow and clear");
    fill_a = {5'd16, 5'd0}; wr_a = 2'b10;
    applyStimulus("ovf_set", M_EN | M_ST | M_OV, 2'b01, 8'h82, 2'b10, 8'h00, 2'b00, 8'h00);
    wr_a = 2'b00;
    applyStimulus("ovf_sticky", M_ST | M_OV, 2'b00, 8'h82, 2'b10, 8'h00, 2'b00, 8'h00);
    clr_a = 2'b11;
    applyStimulus("clr_both", M_OV | M_SC, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00);
    clr_a = 2'b00;
    applyStimulus("stall_count_1", M_OV | M_SC, 2'b00, 8'h00, 2'b00, 8'h10, 2'b00, 8'h00);
    clr_a = 2'b10; wr_a = 2'b10;
    applyStimulus("clr_and_wr", M_OV | M_SC, 2'b00, 8'h00, 2'b10, 8'h00, 2'b00, 8'h00);
    clr_a = 2'b00; wr_a = 2'b00;
    applyStimulus("after_clr_wr", M_OV | M_SC, 2'b00, 8'h00, 2'b10, 8'h10, 2'b00, 8'h00);
    fill_a = '0;
    applyStimulus("ch1_release", M_EN | M_ST | M_SC, 2'b11, 8'h22, 2'b00, 8'h20, 2'b00, 8'h00);
    applyStimulus("ch1_count_hold", M_SC, 2'b00, 8'h00, 2'b00, 8'h20, 2'b00, 8'h00);

    $display("[TB] stall saturation");
    fill_a = {5'd0, 5'd16};
    for (int k = 1; k <= 20; k++) begin
      c = (k - 1 > 15) ? 15 : k - 1;
      applyStimulus($sformatf("sat_%0d", k), M_EN | M_ST | M_SC, 2'b10, 8'h28,
                    2'b00, {4'd2, 4'(c)}, 2'b00, 8'h00);
    end
    fill_a = {5'd0, 5'd31}; wr_a = 2'b01;
    applyStimulus("over_depth", M_ST | M_OV | M_SC, 2'b00, 8'h28, 2'b11, 8'h2f, 2'b00, 8'h00);
    fill_a = {5'd0, 5'd16}; reset = 1'b1;
    applyStimulus("reset_mid_stall", 6'h3f, 2'b11, 8'h11, 2'b00, 8'h00, 2'b11, 8'h11);
    reset = 1'b0; wr_a = 2'b00; fill_a = '0;
    applyStimulus("post_reset2", M_EN | M_ST | M_OV | M_SC, 2'b11, 8'h22, 2'b00, 8'h00, 2'b00, 8'h00);

    $display("[TB] gang mode");
    fill_g = {5'd13, 5'd0};
    applyStimulus("gang_ch1_high", M_GEN | M_GST, 2'b00, 8'h00, 2'b00, 8'h00, 2'b00, 8'h42);
    fill_g = {5'd4, 5'd0};
    applyStimulus("gang_ch1_low", M_GEN | M_GST, 2'b00, 8'h00, 2'b00, 8'h00, 2'b11, 8'h22);
    fill_g = {5'd0, 5'd8};
    applyStimulus("gang_mid", M_GEN | M_GST, 2'b00, 8'h00, 2'b00, 8'h00, 2'b11, 8'h22);
    force dut_g.g_ch[0].u_ch.state_q = 4'b0110;
    #1;
    release dut_g.g_ch[0].u_ch.state_q;
    applyStimulus("gang_fault", M_GEN | M_GST, 2'b00, 8'h00, 2'b00, 8'h00, 2'b11, 8'h21);
    applyStimulus("gang_fault_recover", M_GEN | M_GST, 2'b00, 8'h00, 2'b00, 8'h00, 2'b11, 8'h22);
    fill_g = {5'd0, 5'd12};
    applyStimulus("gang_ch0_high", M_GEN | M_GST | M_EN, 2'b11, 8'h00, 2'b00, 8'h00, 2'b00, 8'h24);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain pending %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
